// File: rtl/stream_dispatcher_pkg.sv
// Shared constants and helpers for the stream dispatcher: error flag
// positions and the bit-width helper used to size tags and FIFO pointers.
package stream_dispatcher_pkg;

    localparam int ERR_W   = 2;
    localparam int ERR_OVF = 0;
    localparam int ERR_TAG = 1;

    // Number of bits needed to represent x (at least 1), so log2(7) = 3, log2(31) = 5.
    function automatic int log2(input int x);
        int r;
        r = 1;
        while ((1 << r) <= x) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/stream_dispatcher_skid.sv
// Two-entry in-order skid stage for one output lane. Words leave when
// valid && !stall at a rising edge; while stalled the head word holds steady.
module stream_dispatcher_skid #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic             room,
    output logic             valid,
    output logic [WIDTH-1:0] q,
    input  logic             stall
);

    logic [1:0]       occ_q, occ_d;
    logic [WIDTH-1:0] e0_q, e0_d;
    logic [WIDTH-1:0] e1_q, e1_d;
    logic             xfer;
    logic [1:0]       pos;

    assign valid = occ_q != 2'd0;
    assign room  = occ_q != 2'd2;
    assign q     = e0_q;
    assign xfer  = valid && !stall;

    always_comb begin
        occ_d = occ_q + {1'b0, load} - {1'b0, xfer};
        e0_d  = e0_q;
        e1_d  = e1_q;
        pos   = occ_q - {1'b0, xfer};
        if (xfer) begin
            e0_d = e1_q;
        end
        // A load lands in the first free slot after any shift; the upstream
        // never loads at occupancy 2, so pos is always 0 or 1 here.
        if (load) begin
            if (pos == 2'd0) begin
                e0_d = d;
            end else begin
                e1_d = d;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q <= 2'd0;
            e0_q  <= '0;
            e1_q  <= '0;
        end else begin
            occ_q <= occ_d;
            e0_q  <= e0_d;
            e1_q  <= e1_d;
        end
    end

endmodule

// File: rtl/stream_dispatcher.sv
// Routes a serialized word stream to PORTS lanes by the tag in each word's
// top bits, through a registered input stage, an input FIFO and per-lane skids.
module stream_dispatcher
    import stream_dispatcher_pkg::*;
#(
    parameter int WIDTH                 = 8,
    parameter int PORTS                 = 8,
    parameter int FIFO_DEPTH            = 32,
    parameter int ALMOST_FULL_THRESHOLD = 1,
    parameter int PORTS_ADDR_WIDTH      = log2(PORTS - 1),
    parameter int FIFO_DEPTH_ADDR_WIDTH = log2(FIFO_DEPTH - 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       d,
    output logic                   full,
    output logic                   almost_full,
    output logic [0:PORTS-1]       valid,
    output logic [WIDTH*PORTS-1:0] q,
    input  logic [0:PORTS-1]       stall,
    output logic [ERR_W-1:0]       err
);

    localparam int AW = FIFO_DEPTH_ADDR_WIDTH;
    localparam int CW = FIFO_DEPTH_ADDR_WIDTH + 1;

    logic                        push_q;
    logic [WIDTH-1:0]            d_q;
    logic [WIDTH-1:0]            mem_q [FIFO_DEPTH];
    logic [AW-1:0]               wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]               count_q;
    logic [ERR_W-1:0]            err_q;
    logic                        wr_en, pop, empty, head_bad, head_room;
    logic [WIDTH-1:0]            head;
    logic [PORTS_ADDR_WIDTH-1:0] head_tag;
    logic [0:PORTS-1]            load, room;

    assign full        = count_q == CW'(FIFO_DEPTH);
    assign almost_full = count_q >= CW'(FIFO_DEPTH - ALMOST_FULL_THRESHOLD);
    assign empty       = count_q == '0;
    assign err         = err_q;
    // Full is judged on the pre-edge count, so a same-cycle pop never admits the push.
    assign wr_en       = push_q && !full;
    assign head        = mem_q[rd_ptr_q];
    assign head_tag    = head[WIDTH-1 -: PORTS_ADDR_WIDTH];
    assign head_bad    = int'(head_tag) >= PORTS;

    always_comb begin
        head_room = 1'b0;
        for (int p = 0; p < PORTS; p++) begin
            if (head_tag == PORTS_ADDR_WIDTH'(p)) begin
                head_room = room[p];
            end
        end
    end

    // Bad-tag heads always drain; good heads wait for their lane (head-of-line blocking).
    assign pop = !empty && (head_bad || head_room);

    always_comb begin
        load = '0;
        for (int p = 0; p < PORTS; p++) begin
            load[p] = pop && !head_bad && (head_tag == PORTS_ADDR_WIDTH'(p));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            push_q   <= 1'b0;
            d_q      <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= '0;
        end else begin
            push_q  <= push;
            d_q     <= d;
            count_q <= count_q + CW'(wr_en) - CW'(pop);
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push_q && full) begin
                err_q[ERR_OVF] <= 1'b1;
            end
            if (pop && head_bad) begin
                err_q[ERR_TAG] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= d_q;
        end
    end

    for (genvar p = 0; p < PORTS; p++) begin : g_lane
        stream_dispatcher_skid #(.WIDTH(WIDTH)) u_skid (
            .clk   (clk),
            .rst   (rst),
            .load  (load[p]),
            .d     (head),
            .room  (room[p]),
            .valid (valid[p]),
            .q     (q[(PORTS-1-p)*WIDTH +: WIDTH]),
            .stall (stall[p])
        );
    end

endmodule

// File: tb/tb_stream_dispatcher.sv
// Directed bench for stream_dispatcher: an 8-lane instance carries the main
// traffic with a per-lane expected queue; a 6-lane instance covers bad tags.
module tb_stream_dispatcher;

    localparam int W     = 8;
    localparam int P     = 8;
    localparam int P6    = 6;
    localparam int DEPTH = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           push8, push6;
    logic [W-1:0]   d8, d6;
    logic           full8, af8, full6, af6;
    logic [0:P-1]   valid8, stall8;
    logic [0:P6-1]  valid6, stall6;
    logic [W*P-1:0] q8;
    logic [W*P6-1:0] q6;
    logic [1:0]     err8, err6;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [W-1:0] exp_q[P][$];
    int           last_xfer[P];
    logic         hold_v[P];
    logic [W-1:0] hold_d[P];
    logic [W-1:0] mon_e;
    bit           bad6_seen = 1'b0;

    always #5 clk = ~clk;

    stream_dispatcher #(.WIDTH(W), .PORTS(P), .FIFO_DEPTH(DEPTH), .ALMOST_FULL_THRESHOLD(1)) u_dut8 (
        .clk(clk), .rst(rst), .push(push8), .d(d8), .full(full8), .almost_full(af8),
        .valid(valid8), .q(q8), .stall(stall8), .err(err8)
    );

    stream_dispatcher #(.WIDTH(W), .PORTS(P6), .FIFO_DEPTH(DEPTH), .ALMOST_FULL_THRESHOLD(1)) u_dut6 (
        .clk(clk), .rst(rst), .push(push6), .d(d6), .full(full6), .almost_full(af6),
        .valid(valid6), .q(q6), .stall(stall6), .err(err6)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] lane8(input int p);
        return q8[(P-1-p)*W +: W];
    endfunction

    // Scoreboard: a word leaving a lane must be the oldest one predicted for it.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            for (int p = 0; p < P; p++) hold_v[p] = 1'b0;
        end else begin
            for (int p = 0; p < P; p++) begin
                if (hold_v[p]) begin
                    check($sformatf("lane%0d_stall_valid", p), 64'(valid8[p]), 64'd1);
                    check($sformatf("lane%0d_stall_q", p), 64'(lane8(p)), 64'(hold_d[p]));
                end
                hold_v[p] = valid8[p] && stall8[p];
                hold_d[p] = lane8(p);
                if (valid8[p] && !stall8[p]) begin
                    last_xfer[p] = cyc;
                    check($sformatf("lane%0d_pending", p), 64'(exp_q[p].size() != 0), 64'd1);
                    if (exp_q[p].size() != 0) begin
                        mon_e = exp_q[p].pop_front();
                        check($sformatf("lane%0d_data", p), 64'(lane8(p)), 64'(mon_e));
                    end
                end
            end
            for (int p = 0; p < P6; p++) begin
                if (valid6[p] && p != 1) bad6_seen = 1'b1;
            end
        end
    end

    task automatic push_word(input logic [W-1:0] w, input bit accept);
        @(posedge clk);
        #1;
        push8 = 1'b1;
        d8    = w;
        if (accept) exp_q[w[W-1 -: 3]].push_back(w);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        push8 = 1'b0;
    endtask

    task automatic set_stall(input logic [0:P-1] v);
        @(posedge clk);
        #1;
        stall8 = v;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        for (int i = 0; i < 300; i++) begin
            n = 0;
            for (int p = 0; p < P; p++) n += exp_q[p].size();
            if (n == 0) break;
            @(negedge clk);
        end
        check(tag, 64'(n), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_latency(input logic [W-1:0] w, input int lane, input string tag);
        logic [0:P-1] one_hot;
        one_hot       = '0;
        one_hot[lane] = 1'b1;
        push_word(w, 1'b1);
        idle();
        @(negedge clk);
        check({tag, "_t1_valid"}, 64'(valid8), 64'd0);
        @(negedge clk);
        check({tag, "_t2_valid"}, 64'(valid8), 64'd0);
        @(negedge clk);
        check({tag, "_t3_valid"}, 64'(valid8), 64'(one_hot));
        check({tag, "_t3_q"}, 64'(lane8(lane)), 64'(w));
        @(negedge clk);
        check({tag, "_t4_valid"}, 64'(valid8), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int  af_idx, full_idx;
        bit  found;

        rst    = 1'b1;
        push8  = 1'b0;
        push6  = 1'b0;
        d8     = '0;
        d6     = '0;
        stall8 = '0;
        stall6 = '0;
        for (int p = 0; p < P; p++) last_xfer[p] = 0;

        // Reset state
        #1;
        check("rst_valid", 64'(valid8), 64'd0);
        check("rst_full", 64'(full8), 64'd0);
        check("rst_af", 64'(af8), 64'd0);
        check("rst_err", 64'(err8), 64'd0);
        check("rst_q", 64'(q8), 64'd0);
        check("rst_valid6", 64'(valid6), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single word, two-cycle latency, one-cycle pulse
        check_latency(8'hA5, 5, "single");

        // Stream of tags 0..7 back to back
        for (int t = 0; t < P; t++) push_word(8'((t << 5) | (t + 3)), 1'b1);
        idle();
        wait_drain("stream_drain");
        for (int t = 1; t < P; t++)
            check($sformatf("stream_spacing%0d", t), 64'(last_xfer[t] - last_xfer[t-1]), 64'd1);
        check("stream_err", 64'(err8), 64'd0);

        // Backpressure on lane 2 with a lane 3 word queued behind
        set_stall(8'b0010_0000);
        push_word(8'h41, 1'b1);
        push_word(8'h42, 1'b1);
        push_word(8'h43, 1'b1);
        push_word(8'h61, 1'b1);
        idle();
        repeat (8) @(negedge clk);
        check("bp_valid", 64'(valid8), 64'(8'b0010_0000));
        check("bp_lane2_q", 64'(lane8(2)), 64'h41);
        check("bp_full", 64'(full8), 64'd0);
        set_stall('0);
        wait_drain("bp_drain");
        check("bp_lane3_after_lane2", 64'(last_xfer[3] > last_xfer[2]), 64'd1);

        // Overflow: every lane stalled, 36 words to lane 0
        set_stall('1);
        af_idx   = -1;
        full_idx = -1;
        for (int i = 0; i < 36; i++) begin
            push_word(8'(i & 31), i < DEPTH + 2);
            @(negedge clk);
            if (af8 && af_idx < 0) af_idx = i;
            if (full8 && full_idx < 0) full_idx = i;
        end
        idle();
        repeat (3) @(negedge clk);
        check("ovf_af_seen", 64'(af_idx >= 0), 64'd1);
        check("ovf_af_lead", 64'(full_idx - af_idx), 64'd1);
        check("ovf_full", 64'(full8), 64'd1);
        check("ovf_af", 64'(af8), 64'd1);
        check("ovf_err", 64'(err8), 64'd1);
        set_stall('0);
        wait_drain("ovf_drain");
        check("ovf_full_after", 64'(full8), 64'd0);
        check("ovf_err_sticky", 64'(err8), 64'd1);

        // Asynchronous reset with words in flight
        set_stall('1);
        for (int i = 0; i < 10; i++) push_word(8'(((i % 8) << 5) | i), 1'b1);
        idle();
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_valid", 64'(valid8), 64'd0);
        check("arst_full", 64'(full8), 64'd0);
        check("arst_af", 64'(af8), 64'd0);
        check("arst_err", 64'(err8), 64'd0);
        for (int p = 0; p < P; p++) exp_q[p].delete();
        @(posedge clk);
        #1;
        rst    = 1'b0;
        stall8 = '0;
        check_latency(8'h9C, 4, "post_rst");
        wait_drain("post_rst_drain");

        // Bad tag on the 6-lane instance
        @(posedge clk);
        #1;
        push6 = 1'b1;
        d6    = 8'hE3;
        @(posedge clk);
        #1;
        d6 = 8'h2A;
        @(posedge clk);
        #1;
        push6 = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (valid6[1]) begin
                found = 1'b1;
                break;
            end
        end
        check("badtag_delivered", 64'(found), 64'd1);
        check("badtag_q", 64'(q6[(P6-2)*W +: W]), 64'h2A);
        check("badtag_err", 64'(err6), 64'h2);
        @(negedge clk);
        check("badtag_valid_after", 64'(valid6), 64'd0);
        repeat (3) @(negedge clk);
        check("badtag_no_stray", 64'(bad6_seen), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/stream_dispatcher.md
Name: stream_dispatcher

Overview:
Downstream counterpart of the multi-port arbiter. It accepts one serialized word stream, buffers it in an input FIFO, and routes each word to one of PORTS output lanes. The destination is a tag held in the word's top bits. Each lane has a 2-entry skid stage with a valid/stall handshake, so a stalled lane does not lose data. The block sits between the arbitrated stream and per-lane consumers.

Parameters:
WIDTH, 8, word width including the destination tag; must be > PORTS_ADDR_WIDTH
PORTS, 8, number of output lanes
FIFO_DEPTH, 32, input FIFO entries; must be a power of two
ALMOST_FULL_THRESHOLD, 1, almost_full asserts when count >= FIFO_DEPTH - ALMOST_FULL_THRESHOLD
PORTS_ADDR_WIDTH, log2(PORTS-1), tag width
FIFO_DEPTH_ADDR_WIDTH, log2(FIFO_DEPTH-1), FIFO pointer width

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
push  input  1  write d into the input FIFO this cycle
d  input  WIDTH  word; tag = d[WIDTH-1 -: PORTS_ADDR_WIDTH]; the whole word, tag included, is forwarded
full  output  1  input FIFO count == FIFO_DEPTH
almost_full  output  1  see ALMOST_FULL_THRESHOLD
valid  output  [0:PORTS-1]  lane p holds a word
q  output  WIDTH*PORTS  lane p word at q[(PORTS-1-p)*WIDTH +: WIDTH]; lane 0 is the MSB slice
stall  input  [0:PORTS-1]  lane p consumer not accepting
err  output  2  sticky flags: bit0 = overflow (push while full), bit1 = bad tag (tag >= PORTS)

Behaviour:
- Reset (asynchronous, takes effect mid-operation as well):
  - FIFO count, pointers and all skid entries cleared.
  - valid = 0, err = 0, full = 0, almost_full = 0 (FIFO_DEPTH > ALMOST_FULL_THRESHOLD).
  - q is don't-care while valid = 0; implementation resets it to 0.
- Input FIFO:
  - A push accepted at edge t makes the word visible at the FIFO head in cycle t+1.
  - Push while full: the word is dropped and err[0] is set. Full is evaluated before that edge's pop, so a simultaneous pop does not admit the push.
  - Push while empty: the word is written; no pop can occur in that cycle.
  - Pointers wrap modulo FIFO_DEPTH.
  - count is FIFO_DEPTH_ADDR_WIDTH+1 bits, and push+pop in the same cycle leaves it unchanged.
- Dispatch (combinational decision, one word per cycle):
  - Pop when the FIFO is not empty and head tag < PORTS and lane[tag] skid occupancy < 2, or when the FIFO is not empty and head tag >= PORTS.
  - A bad-tag word is popped and discarded, and err[1] is set.
  - Head-of-line blocking is intended: a full lane blocks all following words.
- Latency: with the FIFO empty and the lane idle, push at edge t gives valid[p] = 1 and the word on q after edge t+2.
- Lane skid stage (2 entries, in order):
  - Transfer when valid[p] && !stall[p] at a rising edge.
  - While valid[p] && stall[p], q slice p and valid[p] hold stable.
  - A simultaneous transfer-out and load-in at occupancy 2 is impossible, because pop requires occupancy < 2 before the edge.
  - At occupancy 1, load and transfer in the same cycle keep occupancy at 1, and the new word appears next cycle.
  - Throughput is 1 word/cycle per lane with stall = 0.
- Lanes are independent; stall on lane p never affects valid or q on other lanes except through head-of-line blocking.
- err bits stay set until rst.

Decomposition:
- Shared package/include: log2 function (existing log2.vh), tag field extraction macro, err bit index constants.
- Sub-module: stream_dispatcher_skid (parameter WIDTH; ports clk, rst, load, d, room, valid, q, stall).
  - Instantiated PORTS times in a generate loop.
  - The input FIFO reuses the existing std_fifo.

Test Plan:
- Single word: push d = 8'hA5 (tag 5), all stall = 0 -> valid[5] = 1 exactly 2 cycles after push, q slice 5 = A5; all other valid = 0; one cycle wide.
- Stream: 8 words with tags 0..7 pushed back to back -> each lane gets its word, in order, one cycle apart; err = 0.
- Backpressure: stall[2] = 1, push 3 words tagged 2 then 1 word tagged 3 -> lane 2 holds its first word stable with occupancy 2; FIFO head blocks and lane 3 stays invalid. Release stall -> words drain in order, and lane 3 word follows.
- Overflow: stall all lanes, push 36 words to lane 0 -> full after FIFO fill (32 plus 2 skid entries absorbed); almost_full one word earlier; err[0] = 1; the last dropped words never appear.
- Bad tag (PORTS = 6): push tag 7 then tag 1 -> tag 7 discarded, err[1] = 1, tag 1 word delivered normally.
- Reset mid-stream: assert rst asynchronously with 10 words queued -> valid = 0, full = 0, err = 0 immediately; after release a new push is delivered with 2-cycle latency.
